// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU port: FSM states, display mode codes,
// control-register bit positions and the mode decode helper.
package vdp_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WRITE   = 2'd1;
  localparam logic [1:0] RD_ADDR = 2'd2;
  localparam logic [1:0] RD_CAP  = 2'd3;

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_G1   = 2'd1;
  localparam logic [1:0] MODE_G2   = 2'd2;
  localparam logic [1:0] MODE_MC   = 2'd3;

  localparam int R1_IE = 5;
  localparam int R1_M1 = 4;
  localparam int R1_M2 = 3;
  localparam int R0_M3 = 1;

  // M1 beats M3 beats M2; no mode bit set means graphics I.
  function automatic logic [1:0] mode_decode(input logic m1, input logic m2, input logic m3);
    if (m1)      return MODE_TEXT;
    else if (m3) return MODE_G2;
    else if (m2) return MODE_MC;
    else         return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_port.sv
// CPU-side VDP port: data/control port decode, auto-incrementing VRAM pointer,
// read-ahead buffer, eight write-only registers, vblank status flag and n_int.
module vdp_port
  import vdp_pkg::*;
#(
  parameter int          ADDR_W = 14,
  parameter logic [7:0]  RST_R1 = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic              cpu_a0,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_dout,
  input  logic [7:0]        vram_din,
  input  logic              vblank,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       font_addr,
  output logic              n_int
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_buffer;
  logic [7:0]        r_latch;
  logic              r_toggle;
  logic              r_flag;
  logic [1:0]        r_mode;
  logic [7:0]        r_regs [8];

  logic              w_data_wr;
  logic              w_ctrl_wr;
  logic              w_data_rd;
  logic              w_stat_rd;
  logic [ADDR_W-1:0] w_setup_addr;

  assign busy         = (r_state != IDLE);
  assign w_data_wr    = cpu_wr && !cpu_a0 && !busy;
  assign w_ctrl_wr    = cpu_wr &&  cpu_a0 && !busy;
  assign w_data_rd    = cpu_rd && !cpu_a0 && !busy;
  assign w_stat_rd    = cpu_rd &&  cpu_a0;
  assign w_setup_addr = ADDR_W'({cpu_din[5:0], r_latch});

  assign vram_addr       = r_ptr;
  assign vram_dout       = r_buffer;
  assign vram_we         = (r_state == WRITE);
  assign mode            = r_mode;
  assign name_table_addr = {r_regs[2][3:0], 10'b0};
  assign font_addr       = {r_regs[4][2:0], 11'b0};
  assign n_int           = !(r_flag && r_regs[1][R1_IE]);

  always_comb begin
    cpu_dout = 8'h00;
    if (w_stat_rd)      cpu_dout = {r_flag, 7'b0};
    else if (w_data_rd) cpu_dout = r_buffer;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_buffer <= 8'h00;
      r_latch  <= 8'h00;
      r_toggle <= 1'b0;
      r_flag   <= 1'b0;
      r_mode   <= MODE_TEXT;
      for (int i = 0; i < 8; i++) r_regs[i] <= (i == 1) ? RST_R1 : 8'h00;
    end else begin
      if (vblank)         r_flag <= 1'b1;
      else if (w_stat_rd) r_flag <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_data_wr) begin
            r_buffer <= cpu_din;
            r_toggle <= 1'b0;
            r_state  <= WRITE;
          end else if (w_data_rd) begin
            r_toggle <= 1'b0;
            r_state  <= RD_ADDR;
          end else if (w_ctrl_wr && !r_toggle) begin
            r_latch  <= cpu_din;
            r_toggle <= 1'b1;
          end else if (w_ctrl_wr) begin
            r_toggle <= 1'b0;
            if (cpu_din[7]) begin
              r_regs[cpu_din[2:0]] <= r_latch;
              // Mode follows the new R0/R1 value in the same edge as the register.
              if (cpu_din[2:0] == 3'd0)
                r_mode <= mode_decode(r_regs[1][R1_M1], r_regs[1][R1_M2], r_latch[R0_M3]);
              else if (cpu_din[2:0] == 3'd1)
                r_mode <= mode_decode(r_latch[R1_M1], r_latch[R1_M2], r_regs[0][R0_M3]);
            end else begin
              r_ptr <= w_setup_addr;
              if (!cpu_din[6]) r_state <= RD_ADDR;
            end
          end
          if (w_stat_rd) r_toggle <= 1'b0;
        end
        WRITE: begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_state <= IDLE;
          if (w_stat_rd) r_toggle <= 1'b0;
        end
        RD_ADDR: begin
          r_state <= RD_CAP;
          if (w_stat_rd) r_toggle <= 1'b0;
        end
        default: begin
          r_buffer <= vram_din;
          r_ptr    <= r_ptr + ADDR_W'(1);
          r_state  <= IDLE;
          if (w_stat_rd) r_toggle <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port with a behavioural synchronous VRAM model.
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wr, cpu_rd, cpu_a0;
  logic [7:0]  cpu_din, cpu_dout;
  logic        busy;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_dout, vram_din;
  logic        vblank;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, font_addr;
  logic        n_int;

  logic [7:0]  mem [16384];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  rdat;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  mode;
    logic [13:0] nta;
    logic [13:0] fa;
  } reg_vec_t;
  reg_vec_t vecs [10];

  always #5 clk = ~clk;

  vdp_port #(.ADDR_W(14), .RST_R1(8'h00)) dut (
    .clk(clk), .reset(reset),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_a0(cpu_a0),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_dout(vram_dout), .vram_din(vram_din),
    .vblank(vblank), .mode(mode), .name_table_addr(name_table_addr),
    .font_addr(font_addr), .n_int(n_int)
  );

  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_dout;
    vram_din <= mem[vram_addr];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic wr, input logic rd, input logic a0, input logic [7:0] din,
                        input logic vb, output logic [7:0] rd_data);
    @(negedge clk);
    cpu_wr = wr; cpu_rd = rd; cpu_a0 = a0; cpu_din = din; vblank = vb;
    #1 rd_data = cpu_dout;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; vblank = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] d);
    logic [7:0] unused;
    strobe(1'b1, 1'b0, 1'b1, d, 1'b0, unused);
  endtask

  task automatic data_wr(input logic [7:0] d);
    logic [7:0] unused;
    strobe(1'b1, 1'b0, 1'b0, d, 1'b0, unused);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, {15'b0, busy}, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    vecs[0] = '{8'h1F, 8'h82, 2'd0, 14'h3C00, 14'h0000};
    vecs[1] = '{8'h01, 8'h84, 2'd0, 14'h3C00, 14'h0800};
    vecs[2] = '{8'h10, 8'h81, 2'd0, 14'h3C00, 14'h0800};
    vecs[3] = '{8'h08, 8'h81, 2'd3, 14'h3C00, 14'h0800};
    vecs[4] = '{8'h02, 8'h80, 2'd2, 14'h3C00, 14'h0800};
    vecs[5] = '{8'h18, 8'h81, 2'd0, 14'h3C00, 14'h0800};
    vecs[6] = '{8'h00, 8'h81, 2'd2, 14'h3C00, 14'h0800};
    vecs[7] = '{8'h00, 8'hF8, 2'd1, 14'h3C00, 14'h0800};
    vecs[8] = '{8'h07, 8'h8A, 2'd1, 14'h1C00, 14'h0800};
    vecs[9] = '{8'hFF, 8'h84, 2'd1, 14'h1C00, 14'h3800};

    reset = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_a0 = 1'b0; cpu_din = 8'h00; vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {15'b0, vram_we}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_nint", {15'b0, n_int}, 16'h1);
    chk("rst_mode", {14'b0, mode}, 16'h0);
    chk("rst_nta", {2'b0, name_table_addr}, 16'h0);
    chk("rst_font", {2'b0, font_addr}, 16'h0);
    chk("rst_addr", {2'b0, vram_addr}, 16'h0);
    chk("rst_dout", {8'b0, cpu_dout}, 16'h0);
    @(negedge clk) reset = 1'b1;

    // Write setup at 0000 followed by two data writes.
    ctrl(8'h00); ctrl(8'h40);
    data_wr(8'hAA);
    chk("wr1_we", {15'b0, vram_we}, 16'h1);
    chk("wr1_busy", {15'b0, busy}, 16'h1);
    chk("wr1_addr", {2'b0, vram_addr}, 16'h0000);
    chk("wr1_dat", {8'b0, vram_dout}, 16'h00AA);
    wait_idle("wr1_idle");
    data_wr(8'h55);
    chk("wr2_we", {15'b0, vram_we}, 16'h1);
    chk("wr2_addr", {2'b0, vram_addr}, 16'h0001);
    chk("wr2_dat", {8'b0, vram_dout}, 16'h0055);
    wait_idle("wr2_idle");
    chk("wr_we_low", {15'b0, vram_we}, 16'h0);
    chk("wr_ptr", {2'b0, vram_addr}, 16'h0002);
    chk("mem0", {8'b0, mem[0]}, 16'h00AA);
    chk("mem1", {8'b0, mem[1]}, 16'h0055);

    // Read setup with prefetch, then two data reads.
    mem[14'h1234] = 8'h3C; mem[14'h1235] = 8'h7E;
    ctrl(8'h34); ctrl(8'h12);
    chk("rs_busy", {15'b0, busy}, 16'h1);
    chk("rs_addr", {2'b0, vram_addr}, 16'h1234);
    wait_idle("rs_idle");
    chk("rs_ptr", {2'b0, vram_addr}, 16'h1235);
    chk("idle_dout", {8'b0, cpu_dout}, 16'h0000);
    strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, rdat);
    chk("rd1", {8'b0, rdat}, 16'h003C);
    wait_idle("rd1_idle");
    strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, rdat);
    chk("rd2", {8'b0, rdat}, 16'h007E);
    wait_idle("rd2_idle");
    chk("rd_ptr", {2'b0, vram_addr}, 16'h1237);

    // Register writes and derived outputs.
    for (int i = 0; i < 10; i++) begin
      ctrl(vecs[i].lo); ctrl(vecs[i].hi);
      chk($sformatf("reg%0d_mode", i), {14'b0, mode}, {14'b0, vecs[i].mode});
      chk($sformatf("reg%0d_nta", i), {2'b0, name_table_addr}, {2'b0, vecs[i].nta});
      chk($sformatf("reg%0d_font", i), {2'b0, font_addr}, {2'b0, vecs[i].fa});
    end

    // Vblank flag, interrupt and status reads.
    ctrl(8'h20); ctrl(8'h81);
    chk("ie_nint", {15'b0, n_int}, 16'h1);
    @(negedge clk) vblank = 1'b1;
    @(posedge clk) #1 vblank = 1'b0;
    chk("vb_nint", {15'b0, n_int}, 16'h0);
    strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, rdat);
    chk("stat1", {8'b0, rdat}, 16'h0080);
    chk("stat1_nint", {15'b0, n_int}, 16'h1);
    strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, rdat);
    chk("stat_clr", {8'b0, rdat}, 16'h0000);
    strobe(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, rdat);
    chk("vb2_nint", {15'b0, n_int}, 16'h0);
    strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, rdat);
    chk("stat_coinc", {8'b0, rdat}, 16'h0080);
    chk("coinc_nint", {15'b0, n_int}, 16'h0);
    strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, rdat);
    chk("stat3", {8'b0, rdat}, 16'h0080);
    chk("stat3_nint", {15'b0, n_int}, 16'h1);

    // Pointer wrap at the top of VRAM.
    ctrl(8'hFF); ctrl(8'h7F);
    data_wr(8'h11);
    chk("wrap1_addr", {2'b0, vram_addr}, 16'h3FFF);
    wait_idle("wrap1_idle");
    data_wr(8'h22);
    chk("wrap2_addr", {2'b0, vram_addr}, 16'h0000);
    wait_idle("wrap2_idle");
    chk("wrap_ptr", {2'b0, vram_addr}, 16'h0001);
    chk("mem3fff", {8'b0, mem[14'h3FFF]}, 16'h0011);

    // Status read clears the byte toggle; data write while busy is dropped.
    ctrl(8'h12);
    strobe(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, rdat);
    ctrl(8'h00); ctrl(8'h40);
    chk("tog_busy", {15'b0, busy}, 16'h0);
    chk("tog_ptr", {2'b0, vram_addr}, 16'h0000);
    data_wr(8'hBB);
    chk("drop_we1", {15'b0, vram_we}, 16'h1);
    data_wr(8'hCC);
    chk("drop_we2", {15'b0, vram_we}, 16'h0);
    chk("drop_busy", {15'b0, busy}, 16'h0);
    chk("drop_ptr", {2'b0, vram_addr}, 16'h0001);
    chk("drop_mem0", {8'b0, mem[0]}, 16'h00BB);
    chk("drop_mem1", {8'b0, mem[1]}, 16'h0055);

    // Reset in the middle of a VRAM write aborts it.
    data_wr(8'h99);
    chk("mid_we", {15'b0, vram_we}, 16'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", {15'b0, vram_we}, 16'h0);
    chk("mid_rst_busy", {15'b0, busy}, 16'h0);
    chk("mid_rst_mode", {14'b0, mode}, 16'h0);
    chk("mid_rst_nta", {2'b0, name_table_addr}, 16'h0);
    chk("mid_rst_font", {2'b0, font_addr}, 16'h0);
    @(posedge clk) #1;
    chk("mid_rst_mem", {8'b0, mem[1]}, 16'h0055);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vdp_port.md
Name: vdp_port

Overview:
CPU-side I/O front end of the VDP. It is the writer/reader at the CPU end of the dual-port video RAM, whose display side the video generator scans. It decodes TMS9918-style data and control port accesses and owns the 14-bit auto-incrementing VRAM pointer, the read-ahead buffer and the eight write-only registers. It also supplies mode, name-table and font base addresses to the video generator, and the vblank flag and n_int to the Z80.

Parameters:
ADDR_W, 14, VRAM address width (pointer wraps at 2^ADDR_W)
RST_R1, 8'h00, reset value of register R1 (display/int-enable off)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
cpu_wr  in  1  one-cycle write strobe, already edge-detected upstream
cpu_rd  in  1  one-cycle read strobe, already edge-detected upstream
cpu_a0  in  1  port select: 0 = data port (0x98), 1 = control port (0x99)
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data, valid in the cpu_rd cycle
busy  out  1  high while a VRAM transfer is in flight
vram_addr  out  14  to VRAM port A address
vram_we  out  1  to VRAM port A write enable
vram_dout  out  8  to VRAM port A write data
vram_din  in  8  from VRAM port A read data, 1-cycle synchronous latency
vblank  in  1  one-cycle pulse from the video generator at frame end
mode  out  2  0 = text, 1 = graphics I, 2 = graphics II, 3 = multicolour
name_table_addr  out  14  {R2[3:0], 10'b0}
font_addr  out  14  {R4[2:0], 11'b0}
n_int  out  1  active-low interrupt = !(F & R1[5])

Behaviour:
- Reset (async, active-low):
  - R0..R7 = 0, except R1 = RST_R1.
  - Pointer = 0, buffer = 0, first-byte latch = 0, toggle = 0, F = 0, state = IDLE.
  - Outputs: vram_we = 0, busy = 0, n_int = 1, mode = 0, both base addresses = 0.
- Reset mid-transfer aborts the transfer with no VRAM write.
- States: IDLE, WRITE, RD_ADDR, RD_CAP.
- Control write, toggle = 0: latch cpu_din into the first-byte latch; toggle = 1.
- Control write, toggle = 1: toggle = 0. Decode the second byte d:
  - d[7] = 1: register write, R[d[2:0]] <= latch; d[6:3] ignored.
  - d[7:6] = 01: write setup, pointer <= {d[5:0], latch}.
  - d[7:6] = 00: read setup, pointer <= {d[5:0], latch}, then go to RD_ADDR (prefetch).
- Data write: toggle = 0; buffer <= cpu_din; go to WRITE.
  - WRITE (1 cycle): vram_addr = pointer, vram_dout = buffer, vram_we = 1; pointer++; return to IDLE.
  - vram_we is therefore high exactly the cycle after the strobe.
- Data read: cpu_dout = buffer (combinational, strobe cycle); toggle = 0; go to RD_ADDR.
- Prefetch sequence:
  - RD_ADDR drives vram_addr = pointer.
  - RD_CAP: buffer <= vram_din; pointer++; return to IDLE.
  - The new buffer is valid 2 cycles after the strobe.
- Status read:
  - cpu_dout = {F, 7'b0}, using the value before the clear.
  - Then F <= 0 and toggle <= 0.
  - No VRAM access; allowed while busy.
- busy = (state != IDLE). Data-port or control-port strobes that arrive while busy are dropped. Status reads are never dropped.
- Pointer arithmetic is modulo 2^14: 3FFF + 1 = 0000.
- F is set by vblank. If vblank and a status read land in the same cycle, set wins: F stays 1 and the read returns the old F.
- mode is decoded from M1 = R1[4], M2 = R1[3], M3 = R0[1]:
  - M1 -> 0 (text), M3 -> 2, M2 -> 3, else 1.
  - Priority is M1 > M3 > M2.
- All register-derived outputs update the cycle after the second control byte.
- cpu_dout = 8'h00 when no read is in progress.

Decomposition:
- vdp_pkg holds:
  - state enum: IDLE, WRITE, RD_ADDR, RD_CAP
  - mode encodings: MODE_TEXT = 0, MODE_G1 = 1, MODE_G2 = 2, MODE_MC = 3
  - register bit positions: R1_IE = 5, R1_M1 = 4, R1_M2 = 3, R0_M3 = 1
- Single module with no sub-modules; the register file and mode decode are small enough to stay inline.

Test Plan:
1. Control writes 8'h00, 8'h40, then data writes AA, 55 -> vram_we pulses at addr 0000 (AA) and 0001 (55), one cycle after each strobe; pointer = 0002.
2. Preload VRAM 1234 = 3C, 1235 = 7E. Control writes 34, 12 (read setup) -> after 2 cycles buffer = 3C. Data read returns 3C; the next read returns 7E.
3. Control writes 1F, 82 -> R2 = 1F, name_table_addr = 3C00. Writes 01, 84 -> font_addr = 0800. Writes 10, 81 -> mode = 0. Writes 08, 81 -> mode = 3.
4. Set R1 = 20, pulse vblank -> n_int = 0. Status read returns 80 and n_int = 1 next cycle. Vblank coincident with the status read -> F stays 1.
5. Write setup at 3FFF, then two data writes -> addresses 3FFF, then 0000.
6. Single control write 12, then status read, then control writes 00, 40 -> pointer = 0000 (toggle was cleared). A data write issued while busy is dropped (no second vram_we).
